// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline boundary bundle: EX-side payload, pipeline control and the
// registered MEM-side view including the condition-flag outputs.
interface ex_mem_stage_if #(
  parameter int WIDTH    = 64,
  parameter int REG_ADDR = 5
);
  logic                stall;
  logic                flush;
  logic                ex_valid;
  logic [WIDTH-1:0]    ex_result;
  logic                ex_negative;
  logic                ex_zero;
  logic                ex_overflow;
  logic                ex_carry_out;
  logic                ex_set_flags;
  logic [WIDTH-1:0]    ex_store_data;
  logic [REG_ADDR-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_mem_to_reg;

  logic                mem_valid;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    mem_store_data;
  logic [REG_ADDR-1:0] mem_rd;
  logic                mem_reg_write;
  logic                mem_mem_read;
  logic                mem_mem_write;
  logic                mem_mem_to_reg;
  logic                mem_fwd_en;
  logic [3:0]          flags_nzvc;
  logic [3:0]          branch_flags;

  modport master (
    output stall, flush, ex_valid, ex_result, ex_negative, ex_zero, ex_overflow,
           ex_carry_out, ex_set_flags, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_fwd_en,
           flags_nzvc, branch_flags
  );

  modport slave (
    input  stall, flush, ex_valid, ex_result, ex_negative, ex_zero, ex_overflow,
           ex_carry_out, ex_set_flags, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_fwd_en,
           flags_nzvc, branch_flags
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus the architectural NZVC flag register.
// Define EXMEM_FLAG_BYPASS_EN to feed live ALU flags to B.cond resolution in ID.
module ex_mem_stage #(
  parameter int WIDTH    = 64,
  parameter int REG_ADDR = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  ex_mem_stage_if.slave bus
);

  localparam logic [REG_ADDR-1:0] XZR = REG_ADDR'(31);

  typedef struct packed {
    logic                valid;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    store_data;
    logic [REG_ADDR-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } stage_t;

  stage_t     stage_q;
  stage_t     stage_d;
  stage_t     ex_load;
  logic [3:0] flags_q;
  logic [3:0] ex_flags;
  logic       flag_we;

  assign ex_flags = {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out};

  // Control is qualified on entry so MEM never acts on a bubble or an XZR write.
  always_comb begin
    ex_load            = '0;
    ex_load.valid      = bus.ex_valid;
    ex_load.result     = bus.ex_result;
    ex_load.store_data = bus.ex_store_data;
    ex_load.rd         = bus.ex_rd;
    ex_load.reg_write  = bus.ex_reg_write & bus.ex_valid & (bus.ex_rd != XZR);
    ex_load.mem_read   = bus.ex_mem_read & bus.ex_valid;
    ex_load.mem_write  = bus.ex_mem_write & bus.ex_valid;
    ex_load.mem_to_reg = bus.ex_mem_to_reg;
  end

  // Flush wins over stall: a squashed instruction must not linger in MEM.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush)
      stage_d = '0;
    else if (!bus.stall)
      stage_d = ex_load;
  end

  assign flag_we = bus.ex_valid & bus.ex_set_flags & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      flags_q <= 4'b0000;
    end else begin
      stage_q <= stage_d;
      if (flag_we)
        flags_q <= ex_flags;
    end
  end

  assign bus.mem_valid      = stage_q.valid;
  assign bus.mem_result     = stage_q.result;
  assign bus.mem_store_data = stage_q.store_data;
  assign bus.mem_rd         = stage_q.rd;
  assign bus.mem_reg_write  = stage_q.reg_write;
  assign bus.mem_mem_read   = stage_q.mem_read;
  assign bus.mem_mem_write  = stage_q.mem_write;
  assign bus.mem_mem_to_reg = stage_q.mem_to_reg;
  // Load results are not available until WB, so only ALU results forward from here.
  assign bus.mem_fwd_en     = stage_q.reg_write & ~stage_q.mem_read;
  assign bus.flags_nzvc     = flags_q;

`ifdef EXMEM_FLAG_BYPASS_EN
  logic bypass_sel;
  // Stall does not gate the bypass: the setter's flags are what B.cond must see.
  assign bypass_sel       = reset_n & bus.ex_valid & bus.ex_set_flags & ~bus.flush;
  assign bus.branch_flags = bypass_sel ? ex_flags : flags_q;
`else
  assign bus.branch_flags = flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage: vectors are applied between edges, the
// expected MEM-side state is queued at drive time and checked after the edge.
module tb_ex_mem_stage;
  logic clk;
  logic reset_n;

  ex_mem_stage_if #(.WIDTH(64), .REG_ADDR(5)) bus ();

  ex_mem_stage #(.WIDTH(64), .REG_ADDR(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [63:0] res, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, sf;
    logic [3:0]  nzvc;
    logic        e_valid;
    logic [63:0] e_res, e_sd;
    logic [4:0]  e_rd;
    logic [4:0]  e_ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, fwd_en}
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic fl, input logic v,
                     input logic [63:0] r, input logic [63:0] s, input logic [4:0] d,
                     input logic rw, input logic mr, input logic mw, input logic m2r,
                     input logic sf, input logic [3:0] f,
                     input logic ev, input logic [63:0] er, input logic [63:0] es,
                     input logic [4:0] ed, input logic [4:0] ec, input logic [3:0] ef);
    vec_t t;
    t.stall = st; t.flush = fl; t.valid = v; t.res = r; t.sd = s; t.rd = d;
    t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r; t.sf = sf; t.nzvc = f;
    t.e_valid = ev; t.e_res = er; t.e_sd = es; t.e_rd = ed; t.e_ctl = ec; t.e_flags = ef;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    bus.stall         = t.stall;
    bus.flush         = t.flush;
    bus.ex_valid      = t.valid;
    bus.ex_result     = t.res;
    bus.ex_store_data = t.sd;
    bus.ex_rd         = t.rd;
    bus.ex_reg_write  = t.rw;
    bus.ex_mem_read   = t.mr;
    bus.ex_mem_write  = t.mw;
    bus.ex_mem_to_reg = t.m2r;
    bus.ex_set_flags  = t.sf;
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = t.nzvc;
  endtask

  task automatic drive_all(input logic b);
    bus.stall = b; bus.flush = b; bus.ex_valid = b;
    bus.ex_result = {64{b}}; bus.ex_store_data = {64{b}}; bus.ex_rd = {5{b}};
    bus.ex_reg_write = b; bus.ex_mem_read = b; bus.ex_mem_write = b; bus.ex_mem_to_reg = b;
    bus.ex_set_flags = b;
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = {4{b}};
  endtask

  function automatic logic [5:0] ctl_now();
    return {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
            bus.mem_mem_to_reg, bus.mem_fwd_en};
  endfunction

  initial begin
    vec_t       v;
    vec_t       e;
    logic [3:0] prev_flags;
    logic [3:0] exp_bf;

    // Reset table: state after reset has flags 0000.
    add(0,0,1,64'h5,64'hAA,5'd3, 1,0,0,0, 0,4'h0,      1,64'h5,64'hAA,5'd3, 5'b10001,4'h0);
    add(0,0,1,64'h6,64'h0,5'd31, 1,0,0,0, 0,4'h0,      1,64'h6,64'h0,5'd31, 5'b00000,4'h0);
    add(0,0,1,64'h100,64'h0,5'd7, 1,1,0,1, 0,4'h0,     1,64'h100,64'h0,5'd7, 5'b11010,4'h0);
    for (int i = 0; i < 3; i++)
      add(1,0,1,64'h999,64'h11,5'd9, 1,0,1,0, 1,4'hF,  1,64'h100,64'h0,5'd7, 5'b11010,4'h0);
    add(1,1,1,64'h999,64'h11,5'd9, 1,0,1,0, 1,4'hF,    0,64'h0,64'h0,5'd0, 5'b00000,4'h0);
    add(0,0,1,64'h0,64'h0,5'd31, 0,0,0,0, 1,4'b0101,   1,64'h0,64'h0,5'd31, 5'b00000,4'b0101);
    add(0,0,1,64'd12,64'h0,5'd4, 1,0,0,0, 0,4'b0000,   1,64'd12,64'h0,5'd4, 5'b10001,4'b0101);
    add(0,1,1,64'h3,64'h0,5'd4, 1,0,0,0, 1,4'b1010,    0,64'h0,64'h0,5'd0, 5'b00000,4'b0101);
    add(0,0,0,64'd77,64'h5,5'd5, 1,1,1,1, 1,4'hF,      0,64'd77,64'h5,5'd5, 5'b00010,4'b0101);
    add(0,0,1,64'h1,64'h0,5'd1, 1,0,0,0, 1,4'b1000,    1,64'h1,64'h0,5'd1, 5'b10001,4'b1000);
    add(0,0,1,64'h2,64'h0,5'd2, 1,0,0,0, 1,4'b0011,    1,64'h2,64'h0,5'd2, 5'b10001,4'b0011);
    add(0,0,1,64'h40,64'hDEAD,5'd2, 0,0,1,0, 0,4'h0,   1,64'h40,64'hDEAD,5'd2, 5'b00100,4'b0011);
    add(1,0,1,64'h55,64'h0,5'd8, 1,0,0,0, 1,4'b1100,   1,64'h40,64'hDEAD,5'd2, 5'b00100,4'b0011);
    add(0,0,1,64'h55,64'h0,5'd8, 1,0,0,0, 1,4'b1100,   1,64'h55,64'h0,5'd8, 5'b10001,4'b1100);

    // Power-on reset, then a real instruction to leave non-zero state behind.
    reset_n = 1'b0;
    drive_all(1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_result = 64'h1234; bus.ex_rd = 5'd3;
    bus.ex_reg_write = 1'b1; bus.ex_set_flags = 1'b1;
    {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out} = 4'hF;
    @(posedge clk); #1;
    chk("release_result", bus.mem_result, 64'h1234);
    chk("release_flags", {60'd0, bus.flags_nzvc}, 64'hF);

    // Asynchronous reset mid-cycle with every input high.
    @(negedge clk); #2;
    drive_all(1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_ctl", {58'd0, ctl_now()}, 64'h0);
    chk("rst_result", bus.mem_result, 64'h0);
    chk("rst_store", bus.mem_store_data, 64'h0);
    chk("rst_rd", {59'd0, bus.mem_rd}, 64'h0);
    chk("rst_flags", {56'd0, bus.flags_nzvc, bus.branch_flags}, 64'h0);
    // Bypass term must also stay silent with flush low while reset is held.
    bus.flush = 1'b0;
    #1;
    chk("rst_bflags", {60'd0, bus.branch_flags}, 64'h0);
    @(posedge clk); #1;
    chk("rst_hold_ctl", {58'd0, ctl_now()}, 64'h0);

    @(negedge clk);
    reset_n = 1'b1;
    prev_flags = 4'h0;
    foreach (vecs[i]) begin
      v = vecs[i];
      if (i != 0) @(negedge clk);
      drive(v);
      exp_q.push_back(v);
      #1;
`ifdef EXMEM_FLAG_BYPASS_EN
      exp_bf = (v.valid & v.sf & ~v.flush) ? v.nzvc : prev_flags;
`else
      exp_bf = prev_flags;
`endif
      chk($sformatf("v%0d_bflags_pre", i), {60'd0, bus.branch_flags}, {60'd0, exp_bf});
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL v%0d_scoreboard: got empty queue expected entry", i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_result", i), bus.mem_result, e.e_res);
        chk($sformatf("v%0d_store", i), bus.mem_store_data, e.e_sd);
        chk($sformatf("v%0d_rd", i), {59'd0, bus.mem_rd}, {59'd0, e.e_rd});
        chk($sformatf("v%0d_ctl", i), {58'd0, ctl_now()}, {58'd0, e.e_valid, e.e_ctl});
        chk($sformatf("v%0d_flags", i), {60'd0, bus.flags_nzvc}, {60'd0, e.e_flags});
        chk($sformatf("v%0d_bflags_post", i), {60'd0, bus.branch_flags},
            {60'd0, e.e_flags});
        prev_flags = e.e_flags;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish before 20000");
    $fatal(1);
  end
endmodule
